// File: rtl/rstatus_pkg.sv
// Shared constants, FSM encoding and entry-packing helpers for the rstatus write arbiter.
package rstatus_pkg;

    localparam logic [4:0] RSTATUS_REG = 5'd30;

    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        STARVE = 2'd2
    } rs_state_e;

    // Bit 32 tags exception entries so the counter can skip setx writes.
    function automatic logic [32:0] make_exc_entry(input logic [2:0] code);
        return {1'b1, 29'b0, code};
    endfunction

    function automatic logic [32:0] make_setx_entry(input logic [26:0] target);
        return {1'b0, 5'b0, target};
    endfunction

endpackage

// File: rtl/rstatus_fifo.sv
// Circular FIFO of tagged rstatus entries: two ordered write ports, one read port.
module rstatus_fifo
    import rstatus_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push0,
    input  logic [32:0]   din0,
    input  logic          push1,
    input  logic [32:0]   din1,
    input  logic          pop,
    output logic [32:0]   dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage; push1 is only ever used together with push0, so it lands one slot later.
    always_ff @(posedge clock) begin
        if (push0) mem[wr_ptr] <= din0;
        if (push1) mem[wr_ptr + AW'(1)] <= din1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/rstatus_wb_arbiter.sv
// Queues $r30 (rstatus) writes from ALU, multdiv and setx and drains them into idle writeback slots.
// Optional macro RSTATUS_EXC_COUNT_EN enables the exception write counter.
module rstatus_wb_arbiter
    import rstatus_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_exc_valid,
    input  logic [2:0]  alu_exc_code,
    input  logic        setx_valid,
    input  logic [26:0] setx_target,
    input  logic        md_exc_valid,
    input  logic [2:0]  md_exc_code,
    input  logic        wb_busy,
    output logic        rs_we,
    output logic [4:0]  rs_waddr,
    output logic [31:0] rs_wdata,
    output logic        stall,
    output logic        bubble_req,
    output logic [31:0] rstatus,
    output logic        overflow,
    output logic [15:0] exc_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    rs_state_e     state, state_next;
    logic [WW-1:0] wait_cnt, wait_next;
    logic [CW-1:0] count, count_next, free_slots;
    logic          empty, push0, push1, drop;
    logic [32:0]   din0, din1, head;
    logic [32:0]   young_entry;
    logic          young_valid;
    logic [1:0]    n_req;

    rstatus_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push0 (push0),
        .din0  (din0),
        .push1 (push1),
        .din1  (din1),
        .pop   (rs_we),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    // Request compaction: md is older, so it takes port 0; ALU beats setx on a protocol clash.
    always_comb begin
        young_valid = alu_exc_valid | setx_valid;
        young_entry = alu_exc_valid ? make_exc_entry(alu_exc_code) : make_setx_entry(setx_target);
        n_req       = {1'b0, md_exc_valid} + {1'b0, young_valid};
        free_slots  = CW'(DEPTH) - count;
        din0        = md_exc_valid ? make_exc_entry(md_exc_code) : young_entry;
        din1        = young_entry;
        push0       = (n_req != 2'd0) && (free_slots != '0);
        push1       = (n_req == 2'd2) && (free_slots >= CW'(2));
        drop        = CW'(n_req) > free_slots;
    end

    assign rs_we      = !reset && !empty && !wb_busy && (state != IDLE);
    assign rs_wdata   = rs_we ? head[31:0] : 32'b0;
    assign rs_waddr   = RSTATUS_REG;
    assign stall      = (CW'(DEPTH) - count) < CW'(2);
    assign bubble_req = (state == STARVE);
    assign count_next = count + CW'(push0) + CW'(push1) - CW'(rs_we);

    // Next-state and starvation counter.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            IDLE: begin
                if (count_next != '0) state_next = PEND;
                else                  state_next = IDLE;
            end
            PEND, STARVE: begin
                if (rs_we) begin
                    wait_next  = '0;
                    state_next = (count_next == '0) ? IDLE : PEND;
                end else if (wb_busy) begin
                    wait_next = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);
                    if (wait_next == WW'(MAX_WAIT)) state_next = STARVE;
                    else                            state_next = state;
                end else begin
                    state_next = state;
                end
            end
            default: begin
                state_next = IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Shadow of $r30 and sticky drop flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rstatus  <= 32'b0;
            overflow <= 1'b0;
        end else begin
            if (rs_we) rstatus <= rs_wdata;
            if (drop)  overflow <= 1'b1;
        end
    end

`ifdef RSTATUS_EXC_COUNT_EN
    // Saturating count of exception-sourced writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            exc_count <= 16'h0000;
        end else if (rs_we && head[32] && (exc_count != 16'hFFFF)) begin
            exc_count <= exc_count + 16'd1;
        end
    end
`else
    logic unused_tag;
    assign unused_tag = head[32];
    assign exc_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_rstatus_wb_arbiter.sv
// Directed self-checking bench for rstatus_wb_arbiter (honours RSTATUS_EXC_COUNT_EN when defined).
module tb_rstatus_wb_arbiter;

`ifdef RSTATUS_EXC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_exc_valid, setx_valid, md_exc_valid, wb_busy;
    logic [2:0]  alu_exc_code, md_exc_code;
    logic [26:0] setx_target;
    logic        rs_we, stall, bubble_req, overflow;
    logic [4:0]  rs_waddr;
    logic [31:0] rs_wdata, rstatus;
    logic [15:0] exc_count;

    int n_checks = 0;
    int n_errors = 0;

    rstatus_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_exc_valid (alu_exc_valid),
        .alu_exc_code  (alu_exc_code),
        .setx_valid    (setx_valid),
        .setx_target   (setx_target),
        .md_exc_valid  (md_exc_valid),
        .md_exc_code   (md_exc_code),
        .wb_busy       (wb_busy),
        .rs_we         (rs_we),
        .rs_waddr      (rs_waddr),
        .rs_wdata      (rs_wdata),
        .stall         (stall),
        .bubble_req    (bubble_req),
        .rstatus       (rstatus),
        .overflow      (overflow),
        .exc_count     (exc_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic rst, input logic mdv, input logic [2:0] mdc,
                       input logic alv, input logic [2:0] alc,
                       input logic sxv, input logic [26:0] sxt, input logic busy);
        @(posedge clock);
        #1;
        reset = rst; md_exc_valid = mdv; md_exc_code = mdc;
        alu_exc_valid = alv; alu_exc_code = alc;
        setx_valid = sxv; setx_target = sxt; wb_busy = busy;
        @(negedge clock);
    endtask

    task automatic idle(input logic busy);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 27'd0, busy);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset = 1'b1; md_exc_valid = 1'b0; md_exc_code = 3'd0; alu_exc_valid = 1'b0;
        alu_exc_code = 3'd0; setx_valid = 1'b0; setx_target = 27'd0; wb_busy = 1'b0;
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 27'd0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 27'd0, 1'b0);

        // Reset state
        idle(1'b0);
        check_eq("rst_we", rs_we, 0);
        check_eq("rst_waddr", rs_waddr, 30);
        check_eq("rst_wdata", rs_wdata, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_bubble", bubble_req, 0);
        check_eq("rst_rstatus", rstatus, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_cnt", exc_count, 0);

        // 1: ALU sub overflow, written next cycle
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 27'd0, 1'b0);
        check_eq("t1_we_c0", rs_we, 0);
        idle(1'b0);
        check_eq("t1_we_c1", rs_we, 1);
        check_eq("t1_wdata", rs_wdata, 3);
        idle(1'b0);
        check_eq("t1_we_c2", rs_we, 0);
        check_eq("t1_rstatus", rstatus, 3);
        check_eq("t1_cnt", exc_count, exp_cnt(1));

        // 2: md div + ALU add same cycle, md first
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 3'd1, 1'b0, 27'd0, 1'b0);
        idle(1'b0);
        check_eq("t2_we0", rs_we, 1);
        check_eq("t2_wdata0", rs_wdata, 5);
        idle(1'b0);
        check_eq("t2_we1", rs_we, 1);
        check_eq("t2_wdata1", rs_wdata, 1);
        check_eq("t2_rstatus0", rstatus, 5);
        idle(1'b0);
        check_eq("t2_empty", rs_we, 0);
        check_eq("t2_rstatus1", rstatus, 1);
        check_eq("t2_cnt", exc_count, exp_cnt(3));

        // 3: setx held off by three busy cycles
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 27'h123, 1'b1);
        idle(1'b1);
        check_eq("t3_busy1", rs_we, 0);
        idle(1'b1);
        check_eq("t3_busy2", rs_we, 0);
        idle(1'b0);
        check_eq("t3_we", rs_we, 1);
        check_eq("t3_wdata", rs_wdata, 32'h123);
        idle(1'b0);
        check_eq("t3_rstatus", rstatus, 32'h123);
        check_eq("t3_cnt", exc_count, exp_cnt(3));

        // 4: starvation guard after 8 busy cycles
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 27'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            idle(1'b1);
            check_eq("t4_no_bubble", bubble_req, 0);
        end
        idle(1'b1);
        check_eq("t4_bubble", bubble_req, 1);
        check_eq("t4_we_busy", rs_we, 0);
        idle(1'b0);
        check_eq("t4_we", rs_we, 1);
        check_eq("t4_wdata", rs_wdata, 2);
        check_eq("t4_bubble_hold", bubble_req, 1);
        idle(1'b0);
        check_eq("t4_bubble_clr", bubble_req, 0);
        check_eq("t4_cnt", exc_count, exp_cnt(4));

        // ALU and setx together: ALU wins, setx dropped
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 27'h7, 1'b0);
        idle(1'b0);
        check_eq("clash_we", rs_we, 1);
        check_eq("clash_wdata", rs_wdata, 2);
        idle(1'b0);
        check_eq("clash_only1", rs_we, 0);
        check_eq("clash_ovf", overflow, 0);

        // 5: fill, stall, overflow on a 2-request cycle with one free slot
        cyc(1'b0, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0, 27'd0, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 27'd0, 1'b1);
        check_eq("t5_stall_c2", stall, 0);
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 3'd2, 1'b0, 27'd0, 1'b1);
        check_eq("t5_stall_c3", stall, 1);
        check_eq("t5_ovf_pre", overflow, 0);
        idle(1'b1);
        check_eq("t5_ovf", overflow, 1);
        check_eq("t5_stall_full", stall, 1);
        idle(1'b0);
        check_eq("t5_w0", rs_wdata, 4);
        idle(1'b0);
        check_eq("t5_w1", rs_wdata, 1);
        idle(1'b0);
        check_eq("t5_w2", rs_wdata, 3);
        idle(1'b0);
        check_eq("t5_w3", rs_wdata, 5);
        check_eq("t5_we3", rs_we, 1);
        idle(1'b0);
        check_eq("t5_drained", rs_we, 0);
        check_eq("t5_ovf_sticky", overflow, 1);
        check_eq("t5_cnt", exc_count, exp_cnt(9));

        // 6: reset with three entries pending
        cyc(1'b0, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0, 27'd0, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 27'h55, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 27'd0, 1'b0);
        check_eq("t6_we_in_rst", rs_we, 0);
        idle(1'b0);
        check_eq("t6_we", rs_we, 0);
        check_eq("t6_rstatus", rstatus, 0);
        check_eq("t6_ovf", overflow, 0);
        check_eq("t6_stall", stall, 0);
        check_eq("t6_cnt", exc_count, 0);
        idle(1'b0);
        check_eq("t6_we_after", rs_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
